// File: rtl/shared_reg_arb_pkg.sv
// rtl/shared_reg_arb_pkg.sv - shared types and helpers for the shared register arbiter
package shared_reg_arb_pkg;

    typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_e;

    function automatic int unsigned next_idx(input int unsigned idx, input int unsigned n);
        return (idx + 1) % n;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational rotating-priority search starting at ptr
module rr_picker #(
    parameter int NREQ = 4,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic            any,
    output logic [IW-1:0]   winner
);

    logic [IW-1:0] idx;

    // Scan from the farthest offset down so the nearest requester after ptr wins last.
    always_comb begin
        any    = 1'b0;
        winner = '0;
        idx    = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = IW'((int'(ptr) + k) % NREQ);
            if (req[idx]) begin
                any    = 1'b1;
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/shared_reg_arbiter.sv
// rtl/shared_reg_arbiter.sv - round-robin arbiter sharing one register, with bounded lock bursts
module shared_reg_arbiter
    import shared_reg_arb_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int WIDTH    = 8,
    parameter int MAX_LOCK = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ-1:0]          lock,
    input  logic [NREQ*WIDTH-1:0]    wdata,
    output logic [NREQ-1:0]          gnt,
    output logic [WIDTH-1:0]         q,
    output logic                     q_valid,
    output logic [$clog2(NREQ)-1:0]  owner,
    output logic                     busy
);

    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(MAX_LOCK + 1);

    arb_state_e        state_q, state_d;
    logic [IW-1:0]     ptr_q, ptr_d;
    logic [CW-1:0]     lock_cnt_q, lock_cnt_d;
    logic [WIDTH-1:0]  q_q, q_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic              q_valid_q, q_valid_d;
    logic [IW-1:0]     owner_q, owner_d;
    logic              busy_q, busy_d;

    logic              any;
    logic [IW-1:0]     winner;

    rr_picker #(.NREQ(NREQ), .IW(IW)) u_picker (
        .req    (req),
        .ptr    (ptr_q),
        .any    (any),
        .winner (winner)
    );

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        lock_cnt_d = lock_cnt_q;
        q_d        = q_q;
        gnt_d      = gnt_q;
        q_valid_d  = 1'b0;
        owner_d    = owner_q;
        busy_d     = busy_q;
        case (state_q)
            ARB_IDLE: begin
                gnt_d = '0;
                if (any) begin
                    q_d         = wdata[int'(winner)*WIDTH +: WIDTH];
                    gnt_d[winner] = 1'b1;
                    owner_d     = winner;
                    q_valid_d   = 1'b1;
                    if (lock[winner]) begin
                        state_d    = ARB_LOCKED;
                        busy_d     = 1'b1;
                        lock_cnt_d = CW'(1);
                    end else begin
                        ptr_d = IW'(next_idx(int'(winner), NREQ));
                    end
                end
            end
            ARB_LOCKED: begin
                // Release takes priority over a same-cycle write from the owner.
                if (!lock[owner_q] || lock_cnt_q == CW'(MAX_LOCK)) begin
                    gnt_d      = '0;
                    busy_d     = 1'b0;
                    lock_cnt_d = '0;
                    ptr_d      = IW'(next_idx(int'(owner_q), NREQ));
                    state_d    = ARB_IDLE;
                end else begin
                    lock_cnt_d = lock_cnt_q + CW'(1);
                    if (req[owner_q]) begin
                        q_d       = wdata[int'(owner_q)*WIDTH +: WIDTH];
                        q_valid_d = 1'b1;
                    end
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ARB_IDLE;
            ptr_q      <= '0;
            lock_cnt_q <= '0;
            q_q        <= '0;
            gnt_q      <= '0;
            q_valid_q  <= 1'b0;
            owner_q    <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            lock_cnt_q <= lock_cnt_d;
            q_q        <= q_d;
            gnt_q      <= gnt_d;
            q_valid_q  <= q_valid_d;
            owner_q    <= owner_d;
            busy_q     <= busy_d;
        end
    end

    assign gnt     = gnt_q;
    assign q       = q_q;
    assign q_valid = q_valid_q;
    assign owner   = owner_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// tb/tb_shared_reg_arbiter.sv - directed self-checking bench for shared_reg_arbiter
module tb_shared_reg_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [3:0]  lock;
    logic [31:0] wdata;

    logic [3:0]  gnt,  gnt4;
    logic [7:0]  q,    q4;
    logic        q_valid, q_valid4;
    logic [1:0]  owner, owner4;
    logic        busy, busy4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    shared_reg_arbiter #(.NREQ(4), .WIDTH(8), .MAX_LOCK(16)) dut (
        .clk(clk), .reset(reset), .req(req), .lock(lock), .wdata(wdata),
        .gnt(gnt), .q(q), .q_valid(q_valid), .owner(owner), .busy(busy)
    );

    shared_reg_arbiter #(.NREQ(4), .WIDTH(8), .MAX_LOCK(4)) dut_ml4 (
        .clk(clk), .reset(reset), .req(req), .lock(lock), .wdata(wdata),
        .gnt(gnt4), .q(q4), .q_valid(q_valid4), .owner(owner4), .busy(busy4)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        req   = '0;
        lock  = '0;
        wdata = {8'h44, 8'h33, 8'h22, 8'h11};
        tick();
        tick();
        chk("rst_q", q, 0);
        chk("rst_gnt", gnt, 0);
        chk("rst_qv", q_valid, 0);
        chk("rst_owner", owner, 0);
        chk("rst_busy", busy, 0);

        reset = 1'b0;
        tick();
        chk("idle_gnt", gnt, 0);
        chk("idle_qv", q_valid, 0);

        // Reset in the middle of a lock held by requester 2
        req = 4'b0100; lock = 4'b0100;
        tick();
        chk("lk2_owner", owner, 2);
        chk("lk2_busy", busy, 1);
        chk("lk2_q", q, 8'h33);
        req = 4'b0000;
        for (int i = 0; i < 4; i++) tick();
        chk("lk2_hold_gnt", gnt, 4'b0100);
        chk("lk2_hold_busy", busy, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_q", q, 0);
        chk("mid_rst_gnt", gnt, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_owner", owner, 0);
        chk("mid_rst_qv", q_valid, 0);

        // All requesting, no lock: strict rotation from ptr 0
        req = 4'b1111; lock = 4'b0000;
        for (int c = 0; c < 8; c++) begin
            tick();
            chk("rr_owner", owner, c % 4);
            chk("rr_gnt", gnt, 32'd1 << (c % 4));
            chk("rr_qv", q_valid, 1);
            chk("rr_q", q, 8'h11 * ((c % 4) + 1));
        end

        // Pointer wrap: winner 1 moves ptr to 2, then req 0011 wraps to 0
        req = 4'b0010;
        tick();
        chk("wrap_pre_owner", owner, 1);
        req = 4'b0011;
        tick();
        chk("wrap_gnt", gnt, 4'b0001);
        chk("wrap_q", q, 8'h11);
        chk("wrap_owner", owner, 0);
        tick();
        chk("wrap_next_gnt", gnt, 4'b0010);

        // Locked burst by requester 1, voluntary release with req[0] pending
        do_reset();
        wdata[15:8] = 8'hA5; req = 4'b0010; lock = 4'b0010;
        tick();
        chk("lk1_q_a5", q, 8'hA5);
        chk("lk1_gnt", gnt, 4'b0010);
        chk("lk1_busy", busy, 1);
        wdata[15:8] = 8'h3C;
        tick();
        chk("lk1_q_3c", q, 8'h3C);
        chk("lk1_qv", q_valid, 1);
        chk("lk1_busy2", busy, 1);
        wdata[15:8] = 8'h77; req = 4'b0011; lock = 4'b0000;
        tick();
        chk("rel_gnt", gnt, 0);
        chk("rel_qv", q_valid, 0);
        chk("rel_busy", busy, 0);
        chk("rel_q", q, 8'h3C);
        tick();
        chk("post_rel_gnt", gnt, 4'b0001);
        chk("post_rel_q", q, 8'h11);
        chk("post_rel_owner", owner, 0);
        wdata[15:8] = 8'h22;

        // Timeout release with MAX_LOCK=4 on requester 3
        do_reset();
        req = 4'b1000; lock = 4'b1000;
        for (int i = 0; i < 4; i++) begin
            wdata[31:24] = 8'h81 + 8'(i);
            tick();
            chk("to_q", q4, 8'h81 + i);
            chk("to_qv", q_valid4, 1);
            chk("to_gnt", gnt4, 4'b1000);
            chk("to_busy", busy4, 1);
        end
        wdata[31:24] = 8'h85;
        tick();
        chk("to_rel_gnt", gnt4, 0);
        chk("to_rel_qv", q_valid4, 0);
        chk("to_rel_busy", busy4, 0);
        chk("to_rel_q", q4, 8'h84);
        chk("ml16_still_busy", busy, 1);
        chk("ml16_q", q, 8'h85);
        req = 4'b1001; lock = 4'b0000;
        tick();
        chk("to_resume_gnt", gnt4, 4'b0001);
        chk("to_resume_owner", owner4, 0);
        chk("to_resume_q", q4, 8'h11);
        chk("ml16_rel_gnt", gnt, 0);
        wdata[31:24] = 8'h44;

        // Locked owner idle: q holds, grant held, others ignored
        do_reset();
        req = 4'b0001; lock = 4'b0001;
        tick();
        chk("lk0_q", q, 8'h11);
        wdata[7:0] = 8'hEE; req = 4'b0000;
        tick();
        chk("lk0_idle_q", q, 8'h11);
        chk("lk0_idle_qv", q_valid, 0);
        chk("lk0_idle_gnt", gnt, 4'b0001);
        chk("lk0_idle_busy", busy, 1);
        req = 4'b0100;
        tick();
        chk("lk0_other_q", q, 8'h11);
        chk("lk0_other_qv", q_valid, 0);
        chk("lk0_other_gnt", gnt, 4'b0001);
        chk("lk0_other_busy", busy, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
